// File: rtl/delay_scale_estimator_if.sv
// Sample, control and result signals of the delay/scale estimator.
// The stimulus/control side uses master; the estimator uses slave.
interface delay_scale_estimator_if;
    logic               ready_in;
    logic signed [15:0] ambient_in;
    logic signed [15:0] mic_in;
    logic               start_in;
    logic               busy_out;
    logic               done_out;
    logic [7:0]         delay_out;
    logic [4:0]         scale_out;

    modport master (
        output ready_in, ambient_in, mic_in, start_in,
        input  busy_out, done_out, delay_out, scale_out
    );

    modport slave (
        input  ready_in, ambient_in, mic_in, start_in,
        output busy_out, done_out, delay_out, scale_out
    );
endinterface

// File: rtl/delay_scale_estimator.sv
// Sweeps candidate delays, correlating in-ear mic against delayed ambient history.
// Reports the best delay and a saturated scale = corr*64/energy on demand.
module delay_scale_estimator #(
    parameter int MAX_DELAY = 255,
    parameter int WIN_LOG2  = 8
) (
    input logic                    clk_in,
    input logic                    reset_n_in,
    delay_scale_estimator_if.slave bus
);
    localparam int CW = 32 + WIN_LOG2 + 1;
    localparam int EW = 32 + WIN_LOG2;
    localparam int RW = CW + 6;
    localparam int SW = CW + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_ACCUM   = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_DIVIDE  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic signed [CW-1:0] MOST_NEG = {1'b1, {(CW-1){1'b0}}};

    logic [2:0]           state;
    logic signed [15:0]   hist [256];
    logic [7:0]           wp;
    logic [7:0]           fill_cnt;
    logic [7:0]           d;
    logic [WIN_LOG2-1:0]  win_cnt;
    logic signed [CW-1:0] corr;
    logic signed [CW-1:0] best_corr;
    logic [EW-1:0]        energy;
    logic [EW-1:0]        best_energy;
    logic [7:0]           best_delay;
    logic [4:0]           q;
    logic [RW-1:0]        rem;
    logic [2:0]           div_bit;

    logic [7:0]           rd_idx;
    logic signed [15:0]   a_s;
    logic signed [31:0]   prod;
    logic signed [31:0]   sq;
    logic [RW-1:0]        num;
    logic [RW-1:0]        rem_cur;
    logic [RW-1:0]        div_shift;
    logic                 div_ge;
    logic                 div_zero;
    logic                 div_sat;

    // Sample paired with mic_in is read before this strobe's write lands.
    assign rd_idx = wp - d - 8'd1;
    assign a_s    = hist[rd_idx];
    assign prod   = 32'(bus.mic_in) * 32'(a_s);
    assign sq     = 32'(a_s) * 32'(a_s);

    // Restoring division, quotient MSB first; first step uses the fresh numerator.
    assign num       = RW'($unsigned(best_corr)) << 6;
    assign rem_cur   = (div_bit == 3'd4) ? num : rem;
    assign div_shift = RW'(best_energy) << div_bit;
    assign div_ge    = (rem_cur >= div_shift);
    assign div_zero  = best_corr[CW-1] || (best_corr == '0) || (best_energy == '0);
    assign div_sat   = ({$unsigned(best_corr), 1'b0} >= SW'(best_energy));

    // NOTE: the history RAM has no reset; it is fully rewritten by FILL before any use.
    always_ff @(posedge clk_in) begin
        if (bus.ready_in) begin
            hist[wp] <= bus.ambient_in;
        end
    end

    // NOTE: all state uses non-blocking assignment so every branch sees pre-edge values.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state         <= S_IDLE;
            wp            <= '0;
            fill_cnt      <= '0;
            d             <= '0;
            win_cnt       <= '0;
            corr          <= '0;
            energy        <= '0;
            best_corr     <= '0;
            best_energy   <= '0;
            best_delay    <= '0;
            q             <= '0;
            rem           <= '0;
            div_bit       <= '0;
            bus.busy_out  <= 1'b0;
            bus.done_out  <= 1'b0;
            bus.delay_out <= '0;
            bus.scale_out <= '0;
        end else begin
            bus.done_out <= 1'b0;
            if (bus.ready_in) begin
                wp <= wp + 8'd1;
            end
            case (state)
                S_IDLE: begin
                    if (bus.start_in) begin
                        state        <= S_FILL;
                        bus.busy_out <= 1'b1;
                        d            <= '0;
                        best_corr    <= MOST_NEG;
                        best_energy  <= '0;
                        best_delay   <= '0;
                        fill_cnt     <= '0;
                        win_cnt      <= '0;
                        corr         <= '0;
                        energy       <= '0;
                    end
                end
                S_FILL: begin
                    if (bus.ready_in) begin
                        fill_cnt <= fill_cnt + 8'd1;
                        if (fill_cnt == 8'd255) begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (bus.ready_in) begin
                        corr    <= corr + CW'(prod);
                        energy  <= energy + EW'($unsigned(sq));
                        win_cnt <= win_cnt + WIN_LOG2'(1);
                        if (&win_cnt) begin
                            state <= S_COMPARE;
                        end
                    end
                end
                S_COMPARE: begin
                    if (corr > best_corr) begin
                        best_corr   <= corr;
                        best_energy <= energy;
                        best_delay  <= d;
                    end
                    corr    <= '0;
                    energy  <= '0;
                    div_bit <= 3'd4;
                    if (d == 8'(MAX_DELAY)) begin
                        state <= S_DIVIDE;
                    end else begin
                        d     <= d + 8'd1;
                        state <= S_ACCUM;
                    end
                end
                S_DIVIDE: begin
                    if ((div_bit == 3'd4) && div_zero) begin
                        q     <= '0;
                        state <= S_DONE;
                    end else if ((div_bit == 3'd4) && div_sat) begin
                        q     <= 5'd31;
                        state <= S_DONE;
                    end else begin
                        q       <= {q[3:0], div_ge};
                        rem     <= div_ge ? (rem_cur - div_shift) : rem_cur;
                        div_bit <= div_bit - 3'd1;
                        if (div_bit == 3'd0) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    bus.delay_out <= best_delay;
                    bus.scale_out <= q;
                    bus.done_out  <= 1'b1;
                    bus.busy_out  <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/delay_scale_estimator.md
Name: delay_scale_estimator

Overview:
- Calibration block that produces the delay and scale settings consumed by the ambient-path delay/scale filter.
- Correlates the ambient mic stream against the in-ear mic stream over a sweep of candidate delays.
- Selects the delay with the highest correlation and computes scale = corr·64/energy, saturated to 5 bits.
- Runs on demand (start_in); the last estimate is held on the outputs between runs.

Parameters:
- MAX_DELAY, 255: last candidate delay swept (0..MAX_DELAY, ≤255).
- WIN_LOG2, 8: log2 of samples accumulated per candidate delay.

Ports:
- clk_in  input  1  system clock
- reset_n_in  input  1  asynchronous, active-low reset
- ready_in  input  1  sample strobe; ambient_in and mic_in are valid this cycle
- ambient_in  input  16  signed ambient (outer mic) sample
- mic_in  input  16  signed in-ear (error mic) sample
- start_in  input  1  begin an estimation run; ignored while busy_out=1
- busy_out  output  1  high from accepted start until done
- done_out  output  1  one-cycle pulse when delay_out/scale_out update
- delay_out  output  8  estimated delay in samples
- scale_out  output  5  estimated scale numerator over 2^6

Behaviour:
- Reset (async assert, sync-deasserted use): FSM→IDLE; busy_out=0, done_out=0, delay_out=0, scale_out=0; write pointer=0; accumulators cleared. History contents are not cleared.
- History:
  - 256×16 ambient buffer.
  - Every ready_in, in every state: hist[wp]<=ambient_in; wp<=wp+1 (8-bit wrap).
- Pairing convention (same as the filter): at a strobe, mic_in pairs with a=hist[wp−d−1], read before the write, 8-bit modular index.
- States:
  - IDLE: start_in=1 → FILL; busy_out<=1; d<=0; best_corr<=most negative; best_energy<=0; best_delay<=0.
  - FILL: count 256 strobes so history is valid, then → ACCUM.
  - ACCUM: on each strobe, corr+=mic_in·a (signed, 32+WIN_LOG2+1 bits) and energy+=a·a (unsigned, 32+WIN_LOG2 bits). After 2^WIN_LOG2 strobes → COMPARE.
  - COMPARE (1 cycle):
    - If corr>best_corr (signed, strict): best_corr<=corr, best_energy<=energy, best_delay<=d. Ties keep the smaller delay.
    - Clear corr and energy.
    - If d==MAX_DELAY → DIVIDE; else d<=d+1 → ACCUM.
  - DIVIDE:
    - If best_corr≤0 or best_energy==0: q=0, takes 1 cycle.
    - Else if best_corr·64 ≥ 32·best_energy: q=31, takes 1 cycle.
    - Else 5-iteration restoring division, 1 bit/cycle: q=floor(best_corr·64/best_energy). Overflow is impossible by the preceding check.
    - Then → DONE.
  - DONE (1 cycle): delay_out<=best_delay, scale_out<=q, done_out<=1, busy_out<=0 → IDLE.
- Strobes arriving in COMPARE, DIVIDE or DONE write history only and are not accumulated. The next window starts at the first strobe seen in ACCUM. ready_in spacing must be ≥2 cycles.
- start_in while busy_out=1: ignored. start_in in the DONE cycle: ignored. start_in in IDLE the cycle after DONE: accepted.
- Reset asserted mid-run: run aborted; all outputs return to reset values immediately.
- Latency from start: 256 + (MAX_DELAY+1)·2^WIN_LOG2 strobes, plus ≤7 cycles after the last strobe.
- done_out is exactly 1 cycle wide. delay_out/scale_out change only in DONE or on reset.

Test Plan (MAX_DELAY=31, WIN_LOG2=6; ambient_in = 16-bit LFSR white noise, amplitude ≤2^12; strobe every 4 cycles):
- mic[k]=amb[k−11]·16/64 (exact shift) → delay_out=10, scale_out=16, one done_out pulse, busy_out low after.
- mic[k]=0 for all k → scale_out=0, delay_out=0 (all corr equal; tie keeps smallest).
- mic[k]=−amb[k−6] → scale_out=0 (best_corr≤0), done_out pulses once.
- mic[k]=2·amb[k−4] → delay_out=3, scale_out=31 (saturation path).
- Assert reset_n_in=0 during ACCUM at d=12 → busy_out, delay_out, scale_out, done_out all 0 same cycle. Release, rerun case 1 → delay_out=10, scale_out=16.
- Pulse start_in at 5 points during a run → no restart; completion time matches an undisturbed run exactly. Outputs hold the previous estimate until done_out.
